muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair. It is the next generation of the datapath's combinational MD path, with a start/busy/done handshake, configurable width and multiply latency, an iterative divider and a flush input.
- Sits beside the ALU in the EX stage. The pipeline controller stalls MD-dependent instructions while busy=1.

---
 rtl/muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: counted-latency multiply,
// restoring radix-2 divide, MTHI/MTLO writes, start/busy/done handshake and flush.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             sgn_q,   sgn_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             done_q,  done_d;

  // Multiply datapath: operands extended to 2*WIDTH per signedness, low half of product kept.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  always_comb begin
    a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = a_ext * b_ext;
  end

  // Divider step: the quotient register doubles as the dividend shift register.
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] quo_fin,  rem_fin;
  logic             div_zero, div_ovf;

  always_comb begin
    a_mag_in  = (op[0] && A[WIDTH-1]) ? -A : A;
    b_mag     = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, b_mag};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end
    quo_fin  = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_next : quo_next;
    rem_fin  = (sgn_q && a_q[WIDTH-1]) ? -rem_next : rem_next;
    div_zero = (b_q == '0);
    div_ovf  = sgn_q && (a_q == MOST_NEG) && (b_q == ALL_ONES);
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    if (flush) begin
      // Abort wins over start, completion and MTHI/MTLO alike.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULTU, OP_MULT: begin
                a_d     = A;
                b_d     = B;
                sgn_d   = op[0];
                cnt_d   = '0;
                state_d = ST_MUL;
              end
              OP_DIVU, OP_DIV: begin
                a_d     = A;
                b_d     = B;
                sgn_d   = op[0];
                rem_d   = '0;
                quo_d   = a_mag_in;
                cnt_d   = '0;
                state_d = ST_DIV;
              end
              OP_MTLO: lo_d = A;
              OP_MTHI: hi_d = A;
              default: ;
            endcase
          end
        end

        ST_MUL: begin
          if (cnt_q == MUL_LAST) begin
            {hi_d, lo_d} = prod;
            done_d       = 1'b1;
            cnt_d        = '0;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_DIV: begin
          rem_d = rem_next;
          quo_d = quo_next;
          if (cnt_q == DIV_LAST) begin
            if (div_zero) begin
              lo_d = ALL_ONES;
              hi_d = a_q;
            end else if (div_ovf) begin
              lo_d = MOST_NEG;
              hi_d = '0;
            end else begin
              lo_d = quo_fin;
              hi_d = rem_fin;
            end
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} pushed at issue, popped on done.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 5;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors    = 0;
  int checks    = 0;
  int done_seen = 0;

  logic [2*W-1:0] sb_q[$];

  muldiv_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference results from native SV arithmetic, independent of the restoring algorithm.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb, q, r;
    sa = a;
    sb = b;
    case (o)
      OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; return up; end
      OP_MULT:  begin sp = longint'(sa) * longint'(sb); return sp; end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: return 64'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      check("pending_on_done", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) check("result", {hi, lo}, sb_q.pop_front());
    end
  end

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n, input int bound);
    n = 0;
    while (busy && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat);
    int n, d0;
    d0 = done_seen;
    sb_q.push_back(model(o, a, b));
    issue(o, a, b);
    wait_idle(n, lat + 10);
    check("busy_cycles", 64'(n), 64'(lat));
    check("done_on_finish", 64'(done), 64'd1);
    @(negedge clk);
    check("done_pulses", 64'(done_seen - d0), 64'd1);
    check("done_single", 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int n, d0;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("rst_hi",   64'(hi),   64'h0);
    check("rst_lo",   64'(lo),   64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    reset = 1'b1;
    @(negedge clk);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
    check("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
    check("mult_const", {hi, lo}, 64'h0000_0000_0000_0001);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, W);
    check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'd100, 32'd7, W);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});

    run_op(OP_DIVU, 32'h1234, 32'h0, W);
    check("div0_const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, W);
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI then MTLO on consecutive cycles.
    d0    = done_seen;
    op    = OP_MTHI;
    A     = 32'hAAAA_5555;
    start = 1'b1;
    @(negedge clk);
    check("mthi_hi",   64'(hi),   64'hAAAA_5555);
    check("mthi_busy", 64'(busy), 64'h0);
    op = OP_MTLO;
    A  = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo",   64'(lo),   64'h1);
    check("mtlo_hi",   64'(hi),   64'hAAAA_5555);
    check("mtlo_busy", 64'(busy), 64'h0);
    check("mt_no_done", 64'(done_seen - d0), 64'h0);

    // Flush in IDLE blocks a simultaneous MTHI.
    flush = 1'b1;
    op    = OP_MTHI;
    A     = 32'h1234_5678;
    start = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush_idle_hi", 64'(hi), 64'hAAAA_5555);

    // Flush a DIVU on its tenth busy cycle.
    d0 = done_seen;
    issue(OP_DIVU, 32'd50, 32'd3);
    repeat (9) @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'h0);
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(done_seen - d0), 64'h0);
    check("flush_hilo", {hi, lo}, 64'hAAAA_5555_0000_0001);

    // Start while busy is ignored.
    d0 = done_seen;
    sb_q.push_back(model(OP_MULT, 32'hFFFF_FFFD, 32'd5));
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    @(negedge clk);
    op    = OP_DIVU;
    A     = 32'd100;
    B     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n, LAT + 10);
    repeat (45) @(negedge clk);
    check("busy_start_done", 64'(done_seen - d0), 64'h1);
    check("busy_start_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // Asynchronous reset in the middle of a DIV.
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_hi",   64'(hi),   64'h0);
    check("arst_lo",   64'(lo),   64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back: new start on the done cycle.
    sb_q.push_back(model(OP_MULTU, 32'd3, 32'd4));
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_idle(n, LAT + 10);
    check("b2b_first_lat", 64'(n), 64'(LAT));
    check("b2b_done", 64'(done), 64'h1);
    sb_q.push_back(model(OP_DIVU, 32'd100, 32'd7));
    issue(OP_DIVU, 32'd100, 32'd7);
    check("b2b_no_bubble", 64'(busy), 64'h1);
    check("b2b_first_res", {hi, lo}, 64'd12);
    wait_idle(n, W + 10);
    check("b2b_second_lat", 64'(n), 64'(W));
    @(negedge clk);
    check("b2b_second_res", {hi, lo}, {32'd2, 32'd14});

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 3 == 0) ra = -ra;
      run_op(ro, ra, rb, ro[1] ? W : LAT);
    end

    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
